// File: rtl/pll_lock_reset_ctrl_if.sv
// ============================================================================
// Module      : pll_lock_reset_ctrl_if
// Description : Status/control bundle between the PLL reset sequencer and its
//               surroundings (lock/init inputs, reset outputs, debug status).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pll_lock_reset_ctrl_if;
  logic       PLL_LOCK;
  logic       INIT_DONE;
  logic       SW_RESET_REQ;
  logic       FABRIC_RESET_N;
  logic       CPU_RESET_N;
  logic       READY;
  logic [7:0] LOCK_LOSS_CNT;
  logic [2:0] STATE;

  // master drives lock/init/request and observes the reset outputs
  modport master (
    output PLL_LOCK, INIT_DONE, SW_RESET_REQ,
    input  FABRIC_RESET_N, CPU_RESET_N, READY, LOCK_LOSS_CNT, STATE
  );

  modport slave (
    input  PLL_LOCK, INIT_DONE, SW_RESET_REQ,
    output FABRIC_RESET_N, CPU_RESET_N, READY, LOCK_LOSS_CNT, STATE
  );
endinterface

`default_nettype wire

// File: rtl/pll_lock_reset_ctrl.sv
// ============================================================================
// Module      : pll_lock_reset_ctrl
// Description : Filters PLL lock, then releases fabric reset followed by CPU
//               reset; re-asserts both on lock loss or software request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_reset_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CPU_DELAY_CYCLES   = 16,
  parameter int HOLD_CYCLES        = 8,
  parameter int CNT_W              = 16
) (
  input  wire logic             CLK,
  input  wire logic             RESET,
  pll_lock_reset_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_FABRIC    = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cpu_last  = CNT_W'(CPU_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_loss;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_fabric_n;
  logic             r_cpu_n;
  logic             r_ready;
  logic [7:0]       r_loss_cnt;

  // r_sync2 is the synchronized lock (lock_s)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss      = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_sync2 && bus.INIT_DONE) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_STABLE: begin
        if (!r_sync2) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_lock_last) begin
          w_state_nxt = ST_FABRIC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_FABRIC, ST_RUN: begin
        // lock loss takes priority over a coincident software request
        if (!r_sync2) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_loss      = 1'b1;
        end else if (bus.SW_RESET_REQ) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_state == ST_FABRIC) begin
          if (r_cnt == c_cpu_last) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt == c_hold_last) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change glitch-free
  // in the same edge as the state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= ST_WAIT_LOCK;
      r_cnt      <= '0;
      r_fabric_n <= 1'b0;
      r_cpu_n    <= 1'b0;
      r_ready    <= 1'b0;
      r_loss_cnt <= 8'd0;
    end else begin
      r_sync1    <= bus.PLL_LOCK;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fabric_n <= (w_state_nxt == ST_FABRIC) || (w_state_nxt == ST_RUN);
      r_cpu_n    <= (w_state_nxt == ST_RUN);
      r_ready    <= (w_state_nxt == ST_RUN);
      if (w_loss && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

  assign bus.FABRIC_RESET_N = r_fabric_n;
  assign bus.CPU_RESET_N    = r_cpu_n;
  assign bus.READY          = r_ready;
  assign bus.LOCK_LOSS_CNT  = r_loss_cnt;
  assign bus.STATE          = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_reset_ctrl.sv
// ============================================================================
// Module      : tb_pll_lock_reset_ctrl
// Description : Directed bench for pll_lock_reset_ctrl with L=4, D=2, H=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_reset_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  pll_lock_reset_ctrl_if bus ();

  pll_lock_reset_ctrl #(
    .LOCK_STABLE_CYCLES (4),
    .CPU_DELAY_CYCLES   (2),
    .HOLD_CYCLES        (3),
    .CNT_W              (16)
  ) u_dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic fab,
                         input logic cpu, input logic rdy);
    chk({tag, "_state"},  32'(bus.STATE),          32'(st));
    chk({tag, "_fabric"}, 32'(bus.FABRIC_RESET_N), 32'(fab));
    chk({tag, "_cpu"},    32'(bus.CPU_RESET_N),    32'(cpu));
    chk({tag, "_ready"},  32'(bus.READY),          32'(rdy));
  endtask

  always @(negedge clk) begin
    if (!rst && bus.CPU_RESET_N) begin
      chk("order_inv", 32'(bus.FABRIC_RESET_N), 32'd1);
    end
  end

  initial begin
    rst              = 1'b1;
    bus.INIT_DONE    = 1'b1;
    bus.PLL_LOCK     = 1'b0;
    bus.SW_RESET_REQ = 1'b0;

    // Power-up: reset for edges 1..3, lock first sampled at edge 10
    step(1);
    chk_out("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_llc", 32'(bus.LOCK_LOSS_CNT), 32'd0);
    step(2);
    rst = 1'b0;
    step(6);                       // edge 9
    bus.PLL_LOCK = 1'b1;
    step(2);                       // edge 11
    chk_out("pu_e11", 3'd0, 1'b0, 1'b0, 1'b0);
    step(1);                       // edge 12
    chk_out("pu_e12", 3'd1, 1'b0, 1'b0, 1'b0);
    step(3);                       // edge 15
    chk_out("pu_e15", 3'd1, 1'b0, 1'b0, 1'b0);
    step(1);                       // edge 16
    chk_out("pu_e16", 3'd2, 1'b1, 1'b0, 1'b0);
    step(1);                       // edge 17
    chk_out("pu_e17", 3'd2, 1'b1, 1'b0, 1'b0);
    step(1);                       // edge 18
    chk_out("pu_e18", 3'd3, 1'b1, 1'b1, 1'b1);

    // Lock loss in RUN: first low sample at edge 19, resets fall at 21
    bus.PLL_LOCK = 1'b0;
    step(2);                       // edge 20
    chk_out("ll_e20", 3'd3, 1'b1, 1'b1, 1'b1);
    step(1);                       // edge 21
    chk_out("ll_e21", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("ll_cnt1", 32'(bus.LOCK_LOSS_CNT), 32'd1);
    bus.PLL_LOCK = 1'b1;
    step(9);                       // edge 30
    chk_out("relock", 3'd3, 1'b1, 1'b1, 1'b1);

    // Software reset in RUN: HOLD for exactly 3 cycles
    bus.SW_RESET_REQ = 1'b1;
    step(1);                       // edge 31
    bus.SW_RESET_REQ = 1'b0;
    chk_out("sw_e31", 3'd4, 1'b0, 1'b0, 1'b0);
    step(2);                       // edge 33
    chk_out("sw_e33", 3'd4, 1'b0, 1'b0, 1'b0);
    step(1);                       // edge 34
    chk_out("sw_e34", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("sw_llc", 32'(bus.LOCK_LOSS_CNT), 32'd1);
    step(1);                       // edge 35
    chk("sw_e35_state", 32'(bus.STATE), 32'd1);
    // Same request in STABLE is ignored
    bus.SW_RESET_REQ = 1'b1;
    step(1);                       // edge 36
    bus.SW_RESET_REQ = 1'b0;
    chk("sw_stable_ign", 32'(bus.STATE), 32'd1);
    step(5);                       // edge 41
    chk_out("sw_run", 3'd3, 1'b1, 1'b1, 1'b1);

    // Simultaneous lock loss and software request: loss wins
    bus.PLL_LOCK = 1'b0;
    step(2);                       // edge 43, lock_s now 0
    bus.SW_RESET_REQ = 1'b1;
    step(1);                       // edge 44
    bus.SW_RESET_REQ = 1'b0;
    chk_out("sim", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("sim_llc", 32'(bus.LOCK_LOSS_CNT), 32'd2);

    // INIT_DONE low holds WAIT_LOCK despite lock
    bus.INIT_DONE = 1'b0;
    bus.PLL_LOCK  = 1'b1;
    step(10);
    chk("init_hold", 32'(bus.STATE), 32'd0);
    bus.INIT_DONE = 1'b1;
    step(1);                       // edge j
    chk("init_rise", 32'(bus.STATE), 32'd1);

    // Lock bounce during STABLE: back to WAIT_LOCK, not counted
    bus.PLL_LOCK = 1'b0;
    step(1);                       // j+1
    bus.PLL_LOCK = 1'b1;
    step(1);                       // j+2
    chk("bnc_j2", 32'(bus.STATE), 32'd1);
    step(1);                       // j+3
    chk_out("bnc_j3", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("bnc_llc", 32'(bus.LOCK_LOSS_CNT), 32'd2);
    step(1);                       // j+4
    chk("bnc_j4", 32'(bus.STATE), 32'd1);
    step(3);                       // j+7
    chk_out("bnc_j7", 3'd1, 1'b0, 1'b0, 1'b0);
    step(1);                       // j+8
    chk_out("bnc_j8", 3'd2, 1'b1, 1'b0, 1'b0);
    step(2);                       // j+10
    chk_out("bnc_run", 3'd3, 1'b1, 1'b1, 1'b1);

    // 300 further losses: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      bus.PLL_LOCK = 1'b0;
      step(3);
      if (i == 0) begin
        chk("sat_first", 32'(bus.LOCK_LOSS_CNT), 32'd3);
      end
      if (i == 252) begin
        chk("sat_reach", 32'(bus.LOCK_LOSS_CNT), 32'd255);
      end
      bus.PLL_LOCK = 1'b1;
      step(9);
    end
    chk("sat_final", 32'(bus.LOCK_LOSS_CNT), 32'd255);
    chk("sat_run", 32'(bus.STATE), 32'd3);

    // RESET while in FABRIC aborts to reset values
    bus.PLL_LOCK = 1'b0;
    step(3);
    chk("rf_llc", 32'(bus.LOCK_LOSS_CNT), 32'd255);
    bus.PLL_LOCK = 1'b1;
    step(7);
    chk_out("rf_fab", 3'd2, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1);
    chk_out("rf_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rf_rst_llc", 32'(bus.LOCK_LOSS_CNT), 32'd0);
    rst = 1'b0;
    step(2);
    chk("rf_after", 32'(bus.STATE), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
